// File: rtl/irq_entry_ctrl_pkg.sv
// Shared MCU definitions for the interrupt-entry controller:
// `XLEN, the mtvec mode constants and the controller state encodings.
// Optional feature macro: IRQ_ENTRY_WFI_EN (adds the SLEEP state).
`ifndef XLEN
`define XLEN 32
`endif

package irq_entry_ctrl_pkg;

  // mtvec[1:0] mode field; any other value behaves as DIRECT
  localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_VECTORED = 2'd1;

  // Flush counter holds 0..3, enough for FLUSH_CYC of 1..4
  localparam int FLUSH_CNT_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_SAFE = 3'd1,
    ST_FLUSH     = 3'd2,
    ST_TRAP      = 3'd3
`ifdef IRQ_ENTRY_WFI_EN
    ,
    ST_SLEEP     = 3'd4
`endif
  } irq_state_e;

  // Byte offset of a vectored entry: 4 bytes per cause code
  function automatic logic [`XLEN-1:0] vec_offset(input logic [3:0] code);
    return {{(`XLEN-6){1'b0}}, code, 2'b00};
  endfunction

endpackage

// File: rtl/irq_entry_ctrl_vec_calc.sv
// Trap-vector address calculator (purely combinational).
// DIRECT: base; VECTORED: base + 4*cause[3:0]; other modes act as DIRECT.
// Sums wrap modulo 2^XLEN.
`ifndef XLEN
`define XLEN 32
`endif

module irq_vec_calc
  import irq_entry_ctrl_pkg::*;
(
  input  logic [`XLEN-1:0] mtvec,
  input  logic [3:0]       cause_code,
  output logic [`XLEN-1:0] vec_addr
);

  logic [`XLEN-1:0] base_s;

  // Select the entry address from the mtvec mode field
  always_comb begin
    base_s   = {mtvec[`XLEN-1:2], 2'b00};
    vec_addr = base_s;
    case (mtvec[1:0])
      MTVEC_VECTORED: vec_addr = base_s + vec_offset(cause_code);
      MTVEC_DIRECT:   vec_addr = base_s;
      default:        vec_addr = base_s;
    endcase
  end

endmodule

// File: rtl/irq_entry_ctrl.sv
// Interrupt entry controller: waits for a safe commit point, flushes the
// pipe for FLUSH_CYC cycles, writes mepc/mcause and redirects the PC to
// the trap vector. Also handles MRET retirement and, when the macro
// IRQ_ENTRY_WFI_EN is defined, WFI sleep/wake.
// All outputs are registered and decoded from the next state, so each
// output is high exactly during the cycles spent in its state.
`ifndef XLEN
`define XLEN 32
`endif

module irq_entry_ctrl
  import irq_entry_ctrl_pkg::*;
#(
  parameter int FLUSH_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             irq_req,
  input  logic             wfi_irq_req,
  input  logic [`XLEN-1:0] irq_cause,
  input  logic             wfi_exec,
  input  logic             mret_exec,
  input  logic             commit_ok,
  input  logic [`XLEN-1:0] cur_pc,
  input  logic [`XLEN-1:0] mtvec,
  output logic             pipe_flush,
  output logic             pipe_stall,
  output logic             busy,
  output logic             csr_trap_we,
  output logic [`XLEN-1:0] csr_mepc,
  output logic [`XLEN-1:0] csr_mcause,
  output logic             pc_redirect_vld,
  output logic [`XLEN-1:0] pc_redirect_addr,
  output logic             mret_we,
  output logic             core_sleep
);

  // Out-of-range parameter values are clamped into 1..4
  localparam int FLUSH_N = (FLUSH_CYC < 1) ? 1 : ((FLUSH_CYC > 4) ? 4 : FLUSH_CYC);
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LAST = FLUSH_CNT_W'(FLUSH_N - 1);

  irq_state_e             state_r;
  irq_state_e             state_s;
  logic [FLUSH_CNT_W-1:0] flush_cnt_r;
  logic [FLUSH_CNT_W-1:0] cnt_s;
  logic                   latch_cause_s;
  logic                   latch_pc_s;
  logic                   mret_pulse_s;
  logic                   flush_s;
  logic                   stall_s;
  logic                   busy_s;
  logic                   trap_s;
  logic                   sleep_s;
  logic [`XLEN-1:0]       vec_addr_s;

  // Vector is computed from the cause captured at WAIT_SAFE entry
  irq_vec_calc u_vec_calc (
    .mtvec      (mtvec),
    .cause_code (csr_mcause[3:0]),
    .vec_addr   (vec_addr_s)
  );

  // Next-state logic and capture strobes
  always_comb begin
    state_s       = state_r;
    cnt_s         = flush_cnt_r;
    latch_cause_s = 1'b0;
    latch_pc_s    = 1'b0;
    mret_pulse_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // MRET wins; a request seen in the same cycle is re-sampled next cycle
        if (mret_exec) begin
          mret_pulse_s = 1'b1;
        end else if (irq_req) begin
          state_s       = ST_WAIT_SAFE;
          latch_cause_s = 1'b1;
`ifdef IRQ_ENTRY_WFI_EN
        end else if (wfi_exec) begin
          state_s = ST_SLEEP;
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT_SAFE: begin
        // A withdrawn request aborts cleanly without touching the CSRs
        if (!irq_req) begin
          state_s = ST_IDLE;
        end else if (commit_ok) begin
          state_s    = ST_FLUSH;
          latch_pc_s = 1'b1;
          cnt_s      = {FLUSH_CNT_W{1'b0}};
        end else begin
          state_s = ST_WAIT_SAFE;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_r == FLUSH_LAST) begin
          state_s = ST_TRAP;
          cnt_s   = {FLUSH_CNT_W{1'b0}};
        end else begin
          cnt_s = flush_cnt_r + 2'd1;
        end
      end
      ST_TRAP: begin
        state_s = ST_IDLE;
      end
`ifdef IRQ_ENTRY_WFI_EN
      ST_SLEEP: begin
        // A wake with a pending masked request goes straight to the trap path
        if (wfi_irq_req) begin
          if (irq_req) begin
            state_s       = ST_WAIT_SAFE;
            latch_cause_s = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_SLEEP;
        end
      end
`endif
      default: begin
        state_s = ST_IDLE;
        cnt_s   = {FLUSH_CNT_W{1'b0}};
      end
    endcase
  end

  // Output decode of the state being entered
  always_comb begin
    flush_s = 1'b0;
    stall_s = 1'b0;
    busy_s  = 1'b1;
    trap_s  = 1'b0;
    sleep_s = 1'b0;
    case (state_s)
      ST_IDLE:      busy_s  = 1'b0;
      ST_WAIT_SAFE: stall_s = 1'b1;
      ST_FLUSH: begin
        flush_s = 1'b1;
        stall_s = 1'b1;
      end
      ST_TRAP:      trap_s  = 1'b1;
`ifdef IRQ_ENTRY_WFI_EN
      ST_SLEEP: begin
        sleep_s = 1'b1;
        stall_s = 1'b1;
      end
`endif
      default:      busy_s  = 1'b0;
    endcase
  end

  // State, flush counter and registered control outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= ST_IDLE;
      flush_cnt_r     <= {FLUSH_CNT_W{1'b0}};
      pipe_flush      <= 1'b0;
      pipe_stall      <= 1'b0;
      busy            <= 1'b0;
      csr_trap_we     <= 1'b0;
      pc_redirect_vld <= 1'b0;
      mret_we         <= 1'b0;
    end else begin
      state_r         <= state_s;
      flush_cnt_r     <= cnt_s;
      pipe_flush      <= flush_s;
      pipe_stall      <= stall_s;
      busy            <= busy_s;
      csr_trap_we     <= trap_s;
      pc_redirect_vld <= trap_s;
      mret_we         <= mret_pulse_s;
    end
  end

  // Captured trap data: cause, return PC and redirect target
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_mcause       <= {`XLEN{1'b0}};
      csr_mepc         <= {`XLEN{1'b0}};
      pc_redirect_addr <= {`XLEN{1'b0}};
    end else begin
      if (latch_cause_s) begin
        csr_mcause <= irq_cause;
      end
      if (latch_pc_s) begin
        csr_mepc <= cur_pc;
      end
      if (trap_s) begin
        pc_redirect_addr <= vec_addr_s;
      end
    end
  end

`ifdef IRQ_ENTRY_WFI_EN
  logic core_sleep_r;

  // Sleep indicator follows SLEEP state entry/exit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_sleep_r <= 1'b0;
    end else begin
      core_sleep_r <= sleep_s;
    end
  end

  assign core_sleep = core_sleep_r;
`else
  // WFI acts as a NOP; the wake inputs have no function in this build
  logic unused_wfi_s;
  logic unused_sleep_s;
  assign unused_wfi_s   = wfi_exec | wfi_irq_req;
  assign unused_sleep_s = sleep_s;
  assign core_sleep     = 1'b0;
`endif

endmodule

// File: tb/tb_irq_entry_ctrl.sv
// Bench for irq_entry_ctrl: two instances (FLUSH_CYC=1 and FLUSH_CYC=3)
// share all inputs. A vector table and directed sequences check the main
// scenarios; a random phase compares both instances to a reference model.
module tb_irq_entry_ctrl;

`ifdef IRQ_ENTRY_WFI_EN
  localparam bit WFI_EN = 1'b1;
`else
  localparam bit WFI_EN = 1'b0;
`endif
  localparam int FL0 = 1;
  localparam int FL1 = 3;
  localparam int M_IDLE = 0, M_WAIT = 1, M_FLUSH = 2, M_TRAP = 3, M_SLEEP = 4;

  logic        clk, rst_n;
  logic        irq_req, wfi_irq_req, wfi_exec, mret_exec, commit_ok;
  logic [31:0] irq_cause, cur_pc, mtvec;

  logic        o_flush [2], o_stall [2], o_busy [2], o_trap [2];
  logic        o_vld [2], o_mret [2], o_sleep [2];
  logic [31:0] o_mepc [2], o_mcause [2], o_addr [2];

  int vec_cnt = 0;
  int miss_cnt = 0;

  irq_entry_ctrl #(.FLUSH_CYC(FL0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .irq_req(irq_req), .wfi_irq_req(wfi_irq_req),
    .irq_cause(irq_cause), .wfi_exec(wfi_exec), .mret_exec(mret_exec),
    .commit_ok(commit_ok), .cur_pc(cur_pc), .mtvec(mtvec),
    .pipe_flush(o_flush[0]), .pipe_stall(o_stall[0]), .busy(o_busy[0]),
    .csr_trap_we(o_trap[0]), .csr_mepc(o_mepc[0]), .csr_mcause(o_mcause[0]),
    .pc_redirect_vld(o_vld[0]), .pc_redirect_addr(o_addr[0]),
    .mret_we(o_mret[0]), .core_sleep(o_sleep[0]));

  irq_entry_ctrl #(.FLUSH_CYC(FL1)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .irq_req(irq_req), .wfi_irq_req(wfi_irq_req),
    .irq_cause(irq_cause), .wfi_exec(wfi_exec), .mret_exec(mret_exec),
    .commit_ok(commit_ok), .cur_pc(cur_pc), .mtvec(mtvec),
    .pipe_flush(o_flush[1]), .pipe_stall(o_stall[1]), .busy(o_busy[1]),
    .csr_trap_we(o_trap[1]), .csr_mepc(o_mepc[1]), .csr_mcause(o_mcause[1]),
    .pc_redirect_vld(o_vld[1]), .pc_redirect_addr(o_addr[1]),
    .mret_we(o_mret[1]), .core_sleep(o_sleep[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    int          mode;
    int          rem;
    logic [31:0] cause;
    logic [31:0] mepc;
    logic [31:0] addr;
    logic        mretwe;
  } mdl_t;

  mdl_t mdl [2];

  function automatic mdl_t mreset();
    mdl_t z;
    z.mode = M_IDLE; z.rem = 0; z.cause = 32'd0; z.mepc = 32'd0;
    z.addr = 32'd0; z.mretwe = 1'b0;
    return z;
  endfunction

  function automatic logic [31:0] ref_vec(logic [31:0] tv, logic [31:0] c);
    logic [31:0] base;
    base = tv & 32'hFFFF_FFFC;
    if (tv[1:0] == 2'd1) return base + 32'(c[3:0]) * 32'd4;
    return base;
  endfunction

  function automatic mdl_t mstep(mdl_t s, int f);
    mdl_t n;
    n = s;
    n.mretwe = 1'b0;
    case (s.mode)
      M_IDLE: begin
        if (mret_exec) n.mretwe = 1'b1;
        else if (irq_req) begin n.mode = M_WAIT; n.cause = irq_cause; end
        else if (wfi_exec && WFI_EN) n.mode = M_SLEEP;
      end
      M_WAIT: begin
        if (!irq_req) n.mode = M_IDLE;
        else if (commit_ok) begin n.mode = M_FLUSH; n.rem = f; n.mepc = cur_pc; end
      end
      M_FLUSH: begin
        n.rem = s.rem - 1;
        if (n.rem == 0) begin n.mode = M_TRAP; n.addr = ref_vec(mtvec, s.cause); end
      end
      M_TRAP: n.mode = M_IDLE;
      default: begin
        if (wfi_irq_req) begin
          if (irq_req) begin n.mode = M_WAIT; n.cause = irq_cause; end
          else n.mode = M_IDLE;
        end
      end
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl[0] <= mreset();
      mdl[1] <= mreset();
    end else begin
      mdl[0] <= mstep(mdl[0], FL0);
      mdl[1] <= mstep(mdl[1], FL1);
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk_model(input int i);
    mdl_t m;
    m = mdl[i];
    chk($sformatf("rnd%0d_flush", i),  32'(o_flush[i]), 32'(m.mode == M_FLUSH));
    chk($sformatf("rnd%0d_stall", i),  32'(o_stall[i]),
        32'(m.mode == M_WAIT || m.mode == M_FLUSH || m.mode == M_SLEEP));
    chk($sformatf("rnd%0d_busy", i),   32'(o_busy[i]),  32'(m.mode != M_IDLE));
    chk($sformatf("rnd%0d_trap", i),   32'(o_trap[i]),  32'(m.mode == M_TRAP));
    chk($sformatf("rnd%0d_vld", i),    32'(o_vld[i]),   32'(m.mode == M_TRAP));
    chk($sformatf("rnd%0d_mret", i),   32'(o_mret[i]),  32'(m.mretwe));
    chk($sformatf("rnd%0d_sleep", i),  32'(o_sleep[i]), 32'(m.mode == M_SLEEP));
    chk($sformatf("rnd%0d_mepc", i),   o_mepc[i],   m.mepc);
    chk($sformatf("rnd%0d_mcause", i), o_mcause[i], m.cause);
    chk($sformatf("rnd%0d_addr", i),   o_addr[i],   m.addr);
  endtask

  task automatic chk_zero(input string nm, input int i);
    chk({nm, "_ctl"}, {25'd0, o_flush[i], o_stall[i], o_busy[i], o_trap[i],
                       o_vld[i], o_mret[i], o_sleep[i]}, 32'd0);
    chk({nm, "_mepc"}, o_mepc[i], 32'd0);
    chk({nm, "_mcause"}, o_mcause[i], 32'd0);
    chk({nm, "_addr"}, o_addr[i], 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic irq, commit, mret;
    logic flush, stall, busy, trap, mretwe, csr;
  } vec_t;

  localparam int NT = 8;
  vec_t tbl [NT];

  initial begin
    logic [31:0] saved;
    rst_n = 1'b0; irq_req = 1'b0; wfi_irq_req = 1'b0; wfi_exec = 1'b0;
    mret_exec = 1'b0; commit_ok = 1'b1; irq_cause = 32'h8000_000B;
    cur_pc = 32'h0000_2468; mtvec = 32'h0000_0100;

    //          irq   cmt   mret  flush stall busy  trap  mret  csr
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    chk_zero("rst_d1", 0);
    chk_zero("rst_d3", 1);
    rst_n = 1'b1;
    tick();
    chk_zero("idle_d1", 0);

    // Table: trap entry with FLUSH_CYC=1, MRET collision, abort
    for (int r = 0; r < NT; r++) begin
      irq_req = tbl[r].irq; commit_ok = tbl[r].commit; mret_exec = tbl[r].mret;
      tick();
      chk($sformatf("tbl%0d_flush", r), 32'(o_flush[0]), 32'(tbl[r].flush));
      chk($sformatf("tbl%0d_stall", r), 32'(o_stall[0]), 32'(tbl[r].stall));
      chk($sformatf("tbl%0d_busy", r),  32'(o_busy[0]),  32'(tbl[r].busy));
      chk($sformatf("tbl%0d_trap", r),  32'(o_trap[0]),  32'(tbl[r].trap));
      chk($sformatf("tbl%0d_vld", r),   32'(o_vld[0]),   32'(tbl[r].trap));
      chk($sformatf("tbl%0d_mret", r),  32'(o_mret[0]),  32'(tbl[r].mretwe));
      if (tbl[r].csr) begin
        chk($sformatf("tbl%0d_mepc", r),   o_mepc[0],   32'h0000_2468);
        chk($sformatf("tbl%0d_mcause", r), o_mcause[0], 32'h8000_000B);
        chk($sformatf("tbl%0d_addr", r),   o_addr[0],   32'h0000_0100);
      end
    end
    mret_exec = 1'b0;
    repeat (4) tick();

    // Vectored mode
    mtvec = 32'h0000_0101; irq_cause = 32'h8000_0007; commit_ok = 1'b1; irq_req = 1'b1;
    repeat (3) tick();
    irq_req = 1'b0;
    chk("vec_trap", 32'(o_trap[0]), 32'd1);
    chk("vec_addr", o_addr[0], 32'h0000_011C);
    chk("vec_mcause", o_mcause[0], 32'h8000_0007);
    repeat (6) tick();

    // Request withdrawn while waiting for a safe point
    saved = o_mepc[0];
    cur_pc = 32'h0000_5554; commit_ok = 1'b0; irq_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("wait%0d_stall", k), 32'(o_stall[0]), 32'd1);
      chk($sformatf("wait%0d_trap", k), 32'(o_trap[0]), 32'd0);
    end
    irq_req = 1'b0;
    tick();
    chk("abort_busy", 32'(o_busy[0]), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("abort%0d_trap", k), 32'(o_trap[0]), 32'd0);
    end
    chk("abort_mepc", o_mepc[0], saved);
    commit_ok = 1'b1;
    repeat (4) tick();

    // WFI with a simultaneous request: request wins, WFI is a NOP
    wfi_exec = 1'b1; irq_req = 1'b1; commit_ok = 1'b0;
    tick();
    wfi_exec = 1'b0; irq_req = 1'b0;
    chk("wfiirq_sleep", 32'(o_sleep[0]), 32'd0);
    chk("wfiirq_stall", 32'(o_stall[0]), 32'd1);
    tick();
    chk("wfiirq_idle", 32'(o_busy[0]), 32'd0);

    // WFI sleep and wake
    wfi_exec = 1'b1;
    tick();
    wfi_exec = 1'b0;
`ifdef IRQ_ENTRY_WFI_EN
    chk("sleep_on", 32'(o_sleep[0]), 32'd1);
    chk("sleep_stall", 32'(o_stall[0]), 32'd1);
    tick();
    chk("sleep_hold", 32'(o_sleep[0]), 32'd1);
    wfi_irq_req = 1'b1;
    tick();
    wfi_irq_req = 1'b0;
    chk("wake_sleep", 32'(o_sleep[0]), 32'd0);
    chk("wake_busy", 32'(o_busy[0]), 32'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk($sformatf("wake%0d_trap", k), 32'(o_trap[0]), 32'd0);
    end
    wfi_exec = 1'b1;
    tick();
    wfi_exec = 1'b0;
    wfi_irq_req = 1'b1; irq_req = 1'b1; irq_cause = 32'h8000_0003;
    tick();
    wfi_irq_req = 1'b0; irq_req = 1'b0;
    chk("wakeirq_sleep", 32'(o_sleep[0]), 32'd0);
    chk("wakeirq_stall", 32'(o_stall[0]), 32'd1);
    chk("wakeirq_mcause", o_mcause[0], 32'h8000_0003);
    tick();
`else
    chk("nowfi_sleep", 32'(o_sleep[0]), 32'd0);
    chk("nowfi_busy", 32'(o_busy[0]), 32'd0);
    wfi_irq_req = 1'b1;
    tick();
    wfi_irq_req = 1'b0;
    chk("nowfi_wake", 32'(o_busy[0]), 32'd0);
`endif
    commit_ok = 1'b1;
    repeat (6) tick();

    // FLUSH_CYC=3 entry latency: trap 5 cycles after request
    mtvec = 32'h0000_0100; irq_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("lat3_%0d_trap", k), 32'(o_trap[1]), 32'(k == 5));
      chk($sformatf("lat3_%0d_flush", k), 32'(o_flush[1]), 32'(k >= 2 && k <= 4));
    end
    irq_req = 1'b0;
    repeat (6) tick();

    // Reset in the middle of FLUSH (FLUSH_CYC=3)
    irq_req = 1'b1;
    repeat (3) tick();
    chk("midfl_flush", 32'(o_flush[1]), 32'd1);
    rst_n = 1'b0;
    irq_req = 1'b0;
    #1;
    chk_zero("midfl_rst_d3", 1);
    chk_zero("midfl_rst_d1", 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("postrst%0d_trap", k), 32'(o_trap[1]), 32'd0);
      chk($sformatf("postrst%0d_busy", k), 32'(o_busy[1]), 32'd0);
    end
    chk("postrst_mepc", o_mepc[1], 32'd0);

    // Random phase against the reference model
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 7) == 0) irq_req = ~irq_req;
      commit_ok   = ($urandom_range(0, 1) == 0);
      mret_exec   = ($urandom_range(0, 15) == 0);
      wfi_exec    = ($urandom_range(0, 15) == 0);
      wfi_irq_req = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 2))
        0:       irq_cause = 32'h8000_0003;
        1:       irq_cause = 32'h8000_0007;
        default: irq_cause = 32'h8000_000B;
      endcase
      cur_pc = $urandom;
      mtvec  = $urandom;
      tick();
      chk_model(0);
      chk_model(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
